// File: rtl/func_vector_checker.sv
// rtl/func_vector_checker.sv - stimulus sequencer that drives vectors into a small combinational block and checks its output
module func_vector_checker #(
    parameter int                     N_IN   = 5,
    parameter int                     SETTLE = 2,
    parameter logic [(1<<N_IN)-1:0]   TRUTH  = 32'hFFFF_FFFE,
    parameter int                     CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              dut_y,
    output logic [N_IN-1:0]   vec_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic              first_err_valid,
    output logic [N_IN-1:0]   first_err_vec
);

    localparam int KW = N_IN + 1;
    localparam logic [KW-1:0] LAST_EXH  = KW'((1 << N_IN) - 1);
    localparam logic [KW-1:0] LAST_WALK = KW'(N_IN + 1);
    localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

    state_t         state;
    logic [KW-1:0]  k;
    logic           mode_q;
    logic [7:0]     settle_cnt;
    logic [KW-1:0]  last_k;
    logic           mismatch;
    logic           err_sat;

    assign last_k   = mode_q ? LAST_WALK : LAST_EXH;
    assign mismatch = (dut_y != TRUTH[vec_out]);
    assign err_sat  = &err_count;

    // Walking order: all-zero, one-hot from bit 0 upward, then all-ones.
    function automatic logic [N_IN-1:0] vec_of(input logic m, input logic [KW-1:0] idx);
        logic [N_IN-1:0] v;
        v = '0;
        if (!m)
            v = idx[N_IN-1:0];
        else if (idx == '0)
            v = '0;
        else if (idx <= KW'(N_IN))
            v = N_IN'(1) << (idx - KW'(1));
        else
            v = '1;
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            k               <= '0;
            mode_q          <= 1'b0;
            settle_cnt      <= '0;
            vec_out         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mode_q          <= mode;
                        k               <= '0;
                        settle_cnt      <= '0;
                        vec_out         <= vec_of(mode, '0);
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_vec   <= '0;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        busy            <= 1'b1;
                        state           <= APPLY;
                    end
                end
                APPLY: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        if (!err_sat)
                            err_count <= err_count + CNT_W'(1);
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_vec   <= vec_out;
                        end
                    end
                    if (k == last_k) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !mismatch;
                        state <= DONE;
                    end else begin
                        k       <= k + KW'(1);
                        vec_out <= vec_of(mode_q, k + KW'(1));
                        state   <= APPLY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_func_vector_checker.sv
// tb/tb_func_vector_checker.sv - randomized scoreboard bench for func_vector_checker
module tb_func_vector_checker;

    localparam int N = 5;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst, start, mode, dut_y;
    logic [N-1:0] vec_out, first_err_vec;
    logic busy, done, pass, first_err_valid;
    logic [7:0] err_count;

    logic start_s;
    logic [N-1:0] vec_out_s, first_err_vec_s;
    logic busy_s, done_s, pass_s, first_err_valid_s;
    logic [3:0] err_count_s;

    logic [31:0] flip = '0;

    // Modelled DUT: 5-input OR, with selected vectors answered wrongly.
    assign dut_y = (vec_out != '0) ^ flip[vec_out];

    func_vector_checker #(.N_IN(N), .SETTLE(S), .TRUTH(32'hFFFF_FFFE), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .dut_y(dut_y),
        .vec_out(vec_out), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_valid(first_err_valid),
        .first_err_vec(first_err_vec)
    );

    func_vector_checker #(.N_IN(N), .SETTLE(S), .TRUTH(32'hFFFF_FFFE), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .start(start_s), .mode(1'b0), .dut_y(1'b0),
        .vec_out(vec_out_s), .busy(busy_s), .done(done_s), .pass(pass_s),
        .err_count(err_count_s), .first_err_valid(first_err_valid_s),
        .first_err_vec(first_err_vec_s)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [4:0]  vec;
    } vec_exp_t;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  err;
        logic        fv;
        logic [4:0]  fvec;
        logic        pass;
    } done_exp_t;

    vec_exp_t  vq[$];
    done_exp_t dq[$];
    done_exp_t sq[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: vector list from the mode rules, errors wherever the modelled DUT lies.
    task automatic push_run(input logic m, input logic [31:0] f, input int unsigned s0);
        logic [4:0] seq[$];
        int         err;
        logic       fv;
        logic [4:0] fvec;
        done_exp_t  d;
        err = 0; fv = 1'b0; fvec = '0;
        if (m) begin
            seq.push_back(5'h00);
            for (int b = 0; b < N; b++) seq.push_back(5'(1 << b));
            seq.push_back(5'h1F);
        end else begin
            for (int i = 0; i < 32; i++) seq.push_back(5'(i));
        end
        for (int i = 0; i < seq.size(); i++) begin
            vq.push_back('{s0 + i * (S + 1), seq[i]});
            if (f[seq[i]]) begin
                if (err < 255) err++;
                if (!fv) begin fv = 1'b1; fvec = seq[i]; end
            end
        end
        d = '{s0 + seq.size() * (S + 1), 8'(err), fv, fvec, err == 0};
        dq.push_back(d);
    endtask

    task automatic push_sat(input int unsigned s0);
        int         err;
        logic       fv;
        logic [4:0] fvec;
        err = 0; fv = 1'b0; fvec = '0;
        for (int v = 0; v < 32; v++) begin
            if (v != 0) begin
                if (err < 15) err++;
                if (!fv) begin fv = 1'b1; fvec = 5'(v); end
            end
        end
        sq.push_back('{s0 + 32 * (S + 1), 8'(err), fv, fvec, err == 0});
    endtask

    logic done_d = 1'b0;
    always @(negedge clk) begin
        vec_exp_t  e;
        done_exp_t d;
        if (vq.size() > 0 && vq[0].cyc <= cyc) begin
            e = vq.pop_front();
            chk("vec_out", vec_out, e.vec);
            chk("busy_in_run", busy, 1);
            chk("done_in_run", done, 0);
        end
        if (done && !done_d) begin
            if (dq.size() == 0) begin
                chk("unexpected_done", dq.size(), 1);
            end else begin
                d = dq.pop_front();
                chk("done_cycle", cyc, d.cyc);
                chk("err_count", err_count, d.err);
                chk("first_err_valid", first_err_valid, d.fv);
                chk("first_err_vec", first_err_vec, d.fvec);
                chk("pass", pass, d.pass);
                chk("busy_at_done", busy, 0);
            end
        end
        done_d = done;
    end

    logic done_sd = 1'b0;
    always @(negedge clk) begin
        done_exp_t d;
        if (done_s && !done_sd) begin
            if (sq.size() == 0) begin
                chk("sat_unexpected_done", sq.size(), 1);
            end else begin
                d = sq.pop_front();
                chk("sat_done_cycle", cyc, d.cyc);
                chk("sat_err_count", err_count_s, d.err);
                chk("sat_first_err_vec", first_err_vec_s, d.fvec);
                chk("sat_first_err_valid", first_err_valid_s, d.fv);
                chk("sat_pass", pass_s, d.pass);
            end
        end
        done_sd = done_s;
    end

    // Cycle 0 is the period in which start is high; the accepting edge ends it.
    task automatic run(input logic m, input logic [31:0] f, input bit mid, input bit with_sat);
        int unsigned s0;
        int          v;
        v = m ? N + 2 : 32;
        @(negedge clk);
        start = 1'b1; mode = m; flip = f;
        s0 = cyc + 1;
        push_run(m, f, s0);
        if (with_sat) begin
            start_s = 1'b1;
            push_sat(s0);
        end
        @(negedge clk);
        start = 1'b0; start_s = 1'b0; mode = 1'($urandom);
        if (mid) begin
            repeat (9) @(negedge clk);
            start = 1'b1; mode = ~m;
            @(negedge clk);
            start = 1'b0;
        end
        while (cyc < s0 + v * (S + 1)) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vec_out"}, vec_out, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_first_err_valid"}, first_err_valid, 0);
        chk({tag, "_first_err_vec"}, first_err_vec, 0);
    endtask

    initial begin
        int unsigned s0;
        bit saw_done;
        rst = 1'b1; start = 1'b0; mode = 1'b0; start_s = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_zero("reset");
        chk("reset_sat_err", err_count_s, 0);
        chk("reset_sat_busy", busy_s, 0);

        run(1'b0, 32'h0, 1'b1, 1'b1);
        run(1'b1, 32'h0, 1'b0, 1'b0);
        run(1'b0, 32'h8008_0000, 1'b0, 1'b0);
        run(1'b1, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            run(1'($urandom_range(0, 1)), $urandom & $urandom & $urandom, 1'b0, 1'b0);

        @(negedge clk);
        start = 1'b1; mode = 1'b0; flip = '0;
        s0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < s0 + 39) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_zero("abort");
        saw_done = 1'b0;
        repeat (110) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        chk("no_activity_after_abort", saw_done, 0);

        start = 1'b1; rst = 1'b1;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("rst_beats_start_busy", busy, 0);

        run(1'b0, $urandom & $urandom, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        chk("vec_queue_drained", vq.size(), 0);
        chk("done_queue_drained", dq.size(), 0);
        chk("sat_queue_drained", sq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/func_vector_checker.md
Name: func_vector_checker

Overview:
- Parametrised, self-checking stimulus sequencer for small combinational function blocks; successor to the hand-written fixed-vector benches.
- Drives an N_IN-bit input vector into a DUT and samples the DUT's 1-bit output after a programmable settle time.
- Compares each sample against a parameter truth table, counts mismatches and captures the first failing vector.
- Two modes: exhaustive (all 2^N_IN vectors) and walking (all-zero, each one-hot, all-ones).

Parameters:
- N_IN, 5, number of DUT inputs (1..8).
- SETTLE, 2, cycles each vector is held before sampling (1..255).
- TRUTH, 32'hFFFF_FFFE, expected DUT output. Width is 2^N_IN bits; bit k is the expected y when vec_out == k.
- CNT_W, 8, width of the error counter.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a run; ignored while busy.
- mode  input  1  0 = exhaustive, 1 = walking; sampled only on an accepted start.
- dut_y  input  1  DUT output under test.
- vec_out  output  N_IN  stimulus vector to the DUT; bit 0 maps to the DUT's first input.
- busy  output  1  high while a run is in progress.
- done  output  1  high from run completion until the next accepted start or rst.
- pass  output  1  valid when done=1; high if err_count == 0.
- err_count  output  CNT_W  mismatch count; saturates at all-ones.
- first_err_valid  output  1  high once a mismatch has been captured in the current run.
- first_err_vec  output  N_IN  vector value of the first mismatch; 0 when first_err_valid=0.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - Clears all outputs: vec_out=0, busy=0, done=0, pass=0, err_count=0, first_err_valid=0, first_err_vec=0.
  - FSM goes to IDLE.
  - rst during a run aborts it immediately; no done pulse is produced.
- FSM states: IDLE, APPLY, SAMPLE, DONE.
- IDLE:
  - start=1 is accepted: latch mode, set index k=0, clear err_count and the first_err fields, clear done/pass, go to APPLY with busy=1.
- Vector selection:
  - Exhaustive: vec_out = k, for k = 0 .. 2^N_IN-1. V = 2^N_IN vectors.
  - Walking: k=0 gives 0; k=1..N_IN gives 1<<(k-1); k=N_IN+1 gives all-ones. V = N_IN+2 vectors.
- APPLY:
  - vec_out is held stable for SETTLE cycles, counted by a settle counter.
  - Then go to SAMPLE.
- SAMPLE (one cycle):
  - Compare dut_y with TRUTH[vec_out].
  - On mismatch: err_count increments, saturating at all-ones.
  - On the first mismatch of the run: capture first_err_vec = vec_out and set first_err_valid=1.
  - If k == V-1: go to DONE. Otherwise k increments, the next vector is driven, and the FSM returns to APPLY.
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - With the start edge at cycle 0, vector k is driven from cycle 1 + k·(SETTLE+1).
  - DONE is entered, with done=1 and busy=0, at cycle 1 + V·(SETTLE+1).
- DONE:
  - vec_out holds the last vector.
  - done, pass and the error fields are held.
  - start=1 begins a new run directly: the start-edge actions from IDLE apply, the FSM goes to APPLY, and done drops on the accepted edge.
- start while busy:
  - Ignored; no restart and no effect on mode.
- Simultaneous rst and start:
  - rst wins.
- Counter widths:
  - k is N_IN+1 bits wide, so the exhaustive terminal value 2^N_IN-1 is reached without wrap.
  - The settle counter is 8 bits.

Test Plan:
- Exhaustive pass: N_IN=5, SETTLE=2, default TRUTH (5-input OR), bench models the DUT as the OR of vec_out. Pulse start at cycle 0 with mode=0 -> vec_out steps 0..31, changing every 3 cycles; done=1 at cycle 97; pass=1; err_count=0; first_err_valid=0.
- Walking sequence: same setup, mode=1 -> vec_out goes 00000, 00001, 00010, 00100, 01000, 10000, 11111; done at cycle 22; pass=1.
- Fault capture: bench forces dut_y=0 when vec_out is 5'h13 or 5'h1F, exhaustive mode -> err_count=2, first_err_vec=5'h13, first_err_valid=1, pass=0.
- Saturation: CNT_W=4, dut_y tied to 0, N_IN=5, exhaustive -> 31 mismatches; err_count stops at 4'hF; pass=0.
- Control robustness: start pulsed again at cycle 10 mid-run -> run unaffected, done still at cycle 97. Then rst at cycle 40 of a second run -> all outputs 0 next cycle, FSM in IDLE, no done.
- Back-to-back: start in the DONE state with mode=1 -> done drops, new walking run completes 22 cycles later with err_count cleared from the previous run.
